// File: rtl/ode_buf_pkg.sv
// Shared constants and helpers for the buffer_rd_mt_pipe elastic buffer.
package ode_buf_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_NCH   = 2;
    localparam int DEF_DEPTH = 2;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bit offset of channel k inside a packed NCH*WIDTH word.
    function automatic int ch_off(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/buffer_rd_mt_stage.sv
// One elastic register stage: data word plus valid flag.
// Loads when adv_i is high; data only captures valid words so the last
// accepted value is held across bubbles.
module buffer_rd_mt_stage
    import ode_buf_pkg::*;
#(
    parameter int W = 2 * DEF_WIDTH
) (
    input  logic         clk,
    input  logic         rst_async_n_i,
    input  logic         rst_sync_i,
    input  logic         adv_i,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    logic         vld_q;
    logic         vld_d;
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    // Next state: flush wins, otherwise load on advance, otherwise hold.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (rst_sync_i) begin
            vld_d  = 1'b0;
            data_d = '0;
        end else if (adv_i) begin
            vld_d = vld_i;
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/buffer_rd_mt_pipe.sv
// Parametrised elastic pipeline buffer: NCH channels of WIDTH bits through
// DEPTH valid/ready stages with bubble collapsing and a synchronous flush.
// Optional macro BUFFER_RD_MT_OCC_EN adds the registered occupancy output occ.
module buffer_rd_mt_pipe
    import ode_buf_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_async,
    input  logic                 rst_sync,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH*WIDTH-1:0] out_data
`ifdef BUFFER_RD_MT_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] occ
`endif
);

    localparam int W = NCH * WIDTH;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [W-1:0]     stage_data [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
            logic         vld_in;
            logic [W-1:0] data_in;

            // The backward chain adv_i = adv_{i+1} | ~vld_i unrolls to:
            // stage i may advance if downstream accepts or any stage at or
            // after i is empty. Written flat to avoid a combinational loop
            // through the vector.
            assign adv[gi] = out_ready | ~(&vld[DEPTH-1:gi]);

            if (gi == 0) begin : gen_head
                assign vld_in  = in_valid;
                assign data_in = in_data;
            end else begin : gen_body
                assign vld_in  = vld[gi-1];
                assign data_in = stage_data[gi-1];
            end

            buffer_rd_mt_stage #(
                .W (W)
            ) u_stage (
                .clk           (clk),
                .rst_async_n_i (rst_async),
                .rst_sync_i    (rst_sync),
                .adv_i         (adv[gi]),
                .vld_i         (vld_in),
                .data_i        (data_in),
                .vld_o         (vld[gi]),
                .data_o        (stage_data[gi])
            );
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = vld[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

`ifdef BUFFER_RD_MT_OCC_EN
    localparam int OW = occ_w(DEPTH);

    logic          in_xfer;
    logic          out_xfer;
    logic [OW-1:0] occ_q;
    logic [OW-1:0] occ_d;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Occupancy next state: +1 on accept only, -1 on release only.
    always_comb begin
        occ_d = occ_q;
        if (rst_sync) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;

`ifndef SYNTHESIS
    occ_bound_a: assert property (@(posedge clk) disable iff (!rst_async)
                                  32'(occ_q) <= DEPTH);
`endif
`endif

endmodule

// File: tb/tb_buffer_rd_mt_pipe.sv
// Scoreboard bench for buffer_rd_mt_pipe (DEPTH=3, NCH=2, WIDTH=8).
// Driver pushes every accepted word into exp_q; the monitor pops and
// compares on every output transfer.
`timescale 1ns/1ps
module tb_buffer_rd_mt_pipe;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;
    localparam int DEPTH = 3;
    localparam int W     = NCH * WIDTH;

    logic         clk = 1'b0;
    logic         rst_async = 1'b0;
    logic         rst_sync = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef BUFFER_RD_MT_OCC_EN
    logic [1:0]   occ;
`endif

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    buffer_rd_mt_pipe #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_sync  (rst_sync),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef BUFFER_RD_MT_OCC_EN
        ,
        .occ       (occ)
`endif
    );

    function automatic logic [W-1:0] pack(input logic [7:0] w);
        return {~w, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: one compare per output transfer, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_async && !rst_sync && out_valid && out_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got 0x%0h expected no output", out_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    fails++;
                    $display("FAIL out_data: got 0x%0h expected 0x%0h", out_data, e);
                end else begin
                    $display("[TB] out 0x%0h", out_data);
                end
            end
        end
    end

    // Present one word until accepted; cyc returns cycles spent.
    task automatic send(input logic [7:0] w, output int cyc);
        bit done;
        done = 0;
        cyc = 0;
        in_valid = 1'b1;
        in_data  = pack(w);
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pack(w));
                done = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > 200) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: word 0x%0h not accepted", w);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c;
        int idx;
        logic [7:0] bp_words [5];

        // Reset held with a live input.
        in_valid = 1'b1;
        in_data  = 16'hA5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
        end
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef BUFFER_RD_MT_OCC_EN
        chk("rst_occ", 32'(occ), 32'd0);
`endif
        @(posedge clk); #1;
        in_valid  = 1'b0;
        rst_async = 1'b1;
        out_ready = 1'b1;
        step(1);

        // Latency: invisible for DEPTH-1 edges after accept, then visible.
        send(8'h11, c);
        for (int k = 0; k < DEPTH - 1; k++) begin
            @(negedge clk);
            chk("lat_not_yet", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("lat_visible", 32'(out_valid), 32'd1);
        drain();

        // Streaming at one word per cycle.
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), c);
            chk("stream_1per_cycle", 32'(c), 32'd1);
        end
        drain();

        // Backpressure: only DEPTH of five words fit.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) bp_words[i] = 8'h21 + 8'(i);
        idx = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = pack(bp_words[idx]);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(pack(bp_words[idx]));
                idx++;
            end
            @(posedge clk); #1;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        @(negedge clk);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
`ifdef BUFFER_RD_MT_OCC_EN
        chk("bp_occ", 32'(occ), 32'd3);
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        while (idx < 5) begin
            send(bp_words[idx], c);
            idx++;
        end
        drain();

        // Bubble collapse under stall.
        out_ready = 1'b0;
        send(8'h33, c);
        step(2);
        send(8'h44, c);
        step(3);
        @(negedge clk);
        chk("bubble_free_stage", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(8'h55, c);
        chk("bubble_fill_cycles", 32'(c), 32'd1);
        @(negedge clk);
        chk("bubble_full", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        drain();

        // Full pipe with simultaneous accept and release.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h61 + 8'(i), c);
        @(negedge clk);
        chk("full_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'h64 + 8'(i), c);
            chk("full_sim_1per_cycle", 32'(c), 32'd1);
`ifdef BUFFER_RD_MT_OCC_EN
            chk("full_sim_occ", 32'(occ), 32'd3);
`endif
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("full_sim_still_full", 32'(out_valid & ~in_ready), 32'd1);
        @(posedge clk); #1;
        drain();

        // Flush with a concurrent input.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h81 + 8'(i), c);
        in_valid = 1'b1;
        in_data  = pack(8'h99);
        rst_sync = 1'b1;
        @(posedge clk); #1;
        rst_sync = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data", 32'(out_data), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
`ifdef BUFFER_RD_MT_OCC_EN
        chk("flush_occ", 32'(occ), 32'd0);
`endif
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(6);
        send(8'h77, c);
        drain();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buffer_rd_mt_pipe.md
Name: buffer_rd_mt_pipe

Overview:
- Parametrised elastic pipeline buffer between Euler-module stages. Successor to the fixed two-channel, single-stage register buffer.
- Carries NCH parallel data channels of WIDTH bits through DEPTH register stages.
- Uses a valid/ready handshake with bubble collapsing, so upstream and downstream stages can stall independently.
- Synchronous flush (rst_sync) clears in-flight data without using the asynchronous reset.

Parameters:
- WIDTH, 32, bits per channel word
- NCH, 2, number of parallel channels (≥1)
- DEPTH, 2, number of register stages (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst_async  in  1  asynchronous reset, active-low
- rst_sync  in  1  synchronous flush, active-high
- in_valid  in  1  upstream word set valid
- in_ready  out  1  buffer can accept this cycle
- in_data  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  stage DEPTH-1 holds valid data
- out_ready  in  1  downstream accepts
- out_data  out  NCH*WIDTH  same packing as in_data, from stage DEPTH-1

Behaviour:
- State per stage i (0..DEPTH-1): data_i[NCH*WIDTH], vld_i.
- Reset: while rst_async=0, all vld_i=0 and all data_i=0. Resulting outputs: out_valid=0, out_data=0, in_ready=1. Async assert, sync-free deassert.
- Flush: rst_sync=1 at a posedge clears vld_i and data_i, overriding any transfer that cycle. It has no effect while rst_async=0.
- Advance chain, combinational, from the output backwards:
  - adv_{DEPTH-1} = out_ready | ~vld_{DEPTH-1}
  - adv_i = adv_{i+1} | ~vld_i
  - in_ready = adv_0
- Stage load at posedge when adv_i=1:
  - Stage 0 takes in_data and vld_0 = in_valid.
  - Stage i>0 takes data_{i-1} and vld_i = vld_{i-1}.
  - When adv_i=0, the stage holds.
- Data registers load only when the incoming valid is 1; vld still updates to 0. So out_data holds its last accepted value across bubbles.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Latency: a word accepted at edge n with no stalls appears on out_valid after edge n+DEPTH-1 (visible in the cycle following edge n+DEPTH-1). For DEPTH=1 the word is visible the cycle after acceptance.
- Throughput: 1 word/cycle when out_ready is held high.
- Full: all vld_i=1 and out_ready=0 gives in_ready=0. in_data is ignored; upstream must hold it.
- Simultaneous accept and release when full and out_ready=1: in_ready=1 and every stage shifts, so the pipe stays full.
- Bubbles: an invalid stage is always overwritten, so holes collapse under a downstream stall.
- Ordering is strictly FIFO. No word is dropped or duplicated.
- Channels always move together; there is no per-channel valid.
- in_ready depends combinationally on out_ready. This is accepted; no registered-ready mode.

Optional Feature:
- Macro BUFFER_RD_MT_OCC_EN.
- When defined, adds output occ[$clog2(DEPTH+1)-1:0], the count of valid stages:
  - Registered, updated each posedge.
  - Rises by 1 on input transfer only, falls by 1 on output transfer only, unchanged on both or neither.
  - Reset and flush set it to 0.
  - Includes an assertion (simulation only) that occ never exceeds DEPTH.
- When undefined: no occ port, no counter logic. Behaviour is otherwise identical.

Decomposition:
- Package ode_buf_pkg:
  - Default WIDTH/NCH/DEPTH constants
  - Function occ_w(depth) = $clog2(depth+1)
  - Packing helper for channel k slice offset
- Sub-module buffer_rd_mt_stage:
  - One register stage: data + vld, load enable = adv, async/sync clear.
  - Instantiated DEPTH times via generate.
- The adv chain lives in the top.

Test Plan:
- Reset: hold rst_async=0 for 3 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=0, in_ready=1. Release; the first word appears after DEPTH edges.
- Streaming: DEPTH=2, NCH=2, WIDTH=8, out_ready=1; push 1,2,3…10 on both channels (ch1 = ~ch0) -> outputs identical in order, 1/cycle, first output 2 cycles after first accept.
- Backpressure: out_ready=0 while pushing 5 words into DEPTH=3 -> exactly 3 accepted and in_ready=0. Raise out_ready -> the 3 emerge in order, then the remaining 2. No loss, no duplication.
- Bubble collapse: DEPTH=4, push word 0x11, idle 2 cycles, push 0x22, out_ready=0 -> after 4 more cycles vld_3=vld_2=1 and in_ready=1 (2 free stages).
- Full simultaneous: pipe full with out_ready=1 and in_valid=1 for 8 cycles -> in_ready=1 throughout, pipe stays full, 8 words out in order.
- Flush mid-stream: pipe holding 3 words, assert rst_sync=1 one cycle together with in_valid=1 -> next cycle out_valid=0, occ=0 (if BUFFER_RD_MT_OCC_EN), the concurrent input is discarded, and no flushed word ever appears at the output.
